// File: rtl/key_event_scanner.sv
// Strobe generator, key-press edge detector and event FIFO for the hold latches.
// Define KEY_RELEASE_EVT_EN to also queue key-release events.
module key_event_scanner #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         key_held,
    output logic                        tick,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic                        evt_release,
    output logic                        overflow
);

    localparam int unsigned KW = $clog2(NUM_KEYS);
    localparam int unsigned DW = $clog2(TICK_DIV);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef KEY_RELEASE_EVT_EN
    localparam int unsigned EW = KW + 1;
`else
    localparam int unsigned EW = KW;
`endif

    logic [DW-1:0]       div_q, div_d;
    logic                tick_q, tick_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] pend_p_q, pend_p_d, pend_p_nx, newp;
    logic                ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                pop, push, full, p_any;
    logic [KW-1:0]       p_idx;
    logic [EW-1:0]       entry;
`ifdef KEY_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] pend_r_q, pend_r_d, pend_r_nx, newr;
    logic                r_any;
    logic [KW-1:0]       r_idx;
`endif

    // Next-state: divider, sampling, arbitration and FIFO bookkeeping
    always_comb begin
        div_d    = (div_q == DW'(TICK_DIV - 1)) ? '0 : div_q + DW'(1);
        tick_d   = (div_q == DW'(TICK_DIV - 1));
        prev_d   = prev_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        newp     = '0;
        p_any    = 1'b0;
        p_idx    = '0;
        pop      = valid_q && evt_ready;
        full     = (cnt_q == CW'(FIFO_DEPTH));

        // Downward scan leaves the lowest set index in p_idx
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_p_q[i]) begin
                p_any = 1'b1;
                p_idx = KW'(i);
            end
        end
        pend_p_nx = pend_p_q;

`ifdef KEY_RELEASE_EVT_EN
        newr  = '0;
        r_any = 1'b0;
        r_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_r_q[i]) begin
                r_any = 1'b1;
                r_idx = KW'(i);
            end
        end
        pend_r_nx = pend_r_q;
        push      = (p_any || r_any) && (!full || pop);
        entry     = p_any ? {1'b0, p_idx} : {1'b1, r_idx};
        if (push && p_any) pend_p_nx[p_idx] = 1'b0;
        if (push && !p_any) pend_r_nx[r_idx] = 1'b0;
`else
        push  = p_any && (!full || pop);
        entry = p_idx;
        if (push) pend_p_nx[p_idx] = 1'b0;
`endif

        // An edge only counts as lost if its bit is still waiting after this edge's push
        pend_p_d = pend_p_nx;
`ifdef KEY_RELEASE_EVT_EN
        pend_r_d = pend_r_nx;
`endif
        if (tick_q) begin
            newp     = key_held & ~prev_q;
            pend_p_d = pend_p_nx | newp;
            prev_d   = key_held;
            if (|(newp & pend_p_nx)) ovf_d = 1'b1;
`ifdef KEY_RELEASE_EVT_EN
            newr     = prev_q & ~key_held;
            pend_r_d = pend_r_nx | newr;
            if (|(newr & pend_r_nx)) ovf_d = 1'b1;
`endif
        end

        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            prev_q   <= '0;
            pend_p_q <= '0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
            pend_r_q <= '0;
`endif
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            prev_q   <= prev_d;
            pend_p_q <= pend_p_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
`ifdef KEY_RELEASE_EVT_EN
            pend_r_q <= pend_r_d;
`endif
        end
    end

    assign tick      = tick_q;
    assign evt_valid = valid_q;
    assign evt_key   = mem_q[rd_ptr_q][KW-1:0];
    assign overflow  = ovf_q;
`ifdef KEY_RELEASE_EVT_EN
    assign evt_release = mem_q[rd_ptr_q][KW];
`else
    assign evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_scanner.sv
// Bench for key_event_scanner: directed scenarios plus random traffic against a queue model.
module tb_key_event_scanner;

    localparam int NK = 4;
    localparam int TD = 4;
    localparam int FD = 4;
`ifdef KEY_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_held = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       tick, evt_valid, evt_release, overflow;
    logic [1:0] evt_key;

    int checks = 0;
    int failures = 0;

    key_event_scanner #(.NUM_KEYS(NK), .TICK_DIV(TD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .key_held(key_held), .tick(tick),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_release(evt_release), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: events are ints (key, or key+NK for a release) in a queue
    int       m_div;
    bit       m_tick;
    bit [3:0] m_prev, m_pp, m_pr;
    bit       m_ovf;
    int       m_q[$];

    always @(posedge clk) begin : model
        int cand;
        bit mpop, mpush;
        if (reset) begin
            m_div = 0; m_tick = 0; m_prev = 0; m_pp = 0; m_pr = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            mpop = (m_q.size() > 0) && evt_ready;
            cand = -1;
            for (int i = 0; i < NK; i++) if (m_pp[i] && cand < 0) cand = i;
            if (REL && cand < 0)
                for (int i = 0; i < NK; i++) if (m_pr[i] && cand < 0) cand = i + NK;
            mpush = (cand >= 0) && (m_q.size() < FD || mpop);
            if (mpop) void'(m_q.pop_front());
            if (mpush) begin
                m_q.push_back(cand);
                if (cand < NK) m_pp[cand] = 1'b0;
                else m_pr[cand - NK] = 1'b0;
            end
            if (m_tick) begin
                for (int i = 0; i < NK; i++) begin
                    if (key_held[i] && !m_prev[i]) begin
                        if (m_pp[i]) m_ovf = 1'b1;
                        m_pp[i] = 1'b1;
                    end
                    if (REL && !key_held[i] && m_prev[i]) begin
                        if (m_pr[i]) m_ovf = 1'b1;
                        m_pr[i] = 1'b1;
                    end
                end
                m_prev = key_held;
            end
            m_tick = (m_div == TD - 1);
            m_div  = (m_div + 1) % TD;
        end
    end

    // Returns at the negedge of the next tick cycle; keys set right after are sampled at its edge
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!m_tick && n < 3 * TD) begin
            @(negedge clk);
            n++;
        end
        if (!m_tick) begin
            checks++; failures++;
            $display("FAIL wait_tick no tick within %0d cycles", 3 * TD);
        end
    endtask

    task automatic test_reset();
        bit exp_t;
        reset = 1'b1; key_held = 4'b0000; evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_key !== 2'd0 || evt_release !== 1'b0) begin
            failures++; $display("FAIL reset_head got key=%0d rel=%b exp key=0 rel=0", evt_key, evt_release); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_t = (k % TD == 0);
            checks++; if (tick !== exp_t) begin failures++; $display("FAIL tick_period cyc=%0d got=%b exp=%b", k, tick, exp_t); end
            checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
                failures++; $display("FAIL idle_quiet cyc=%0d got valid=%b ovf=%b exp 0 0", k, evt_valid, overflow); end
        end
    endtask

    task automatic test_single_press();
        evt_ready = 1'b1;
        wait_tick();
        key_held = 4'b0100;
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL press_lat1 got valid=%b exp=0", evt_valid); end
        @(negedge clk);
        checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd2 || evt_release !== 1'b0) begin
            failures++; $display("FAIL press_lat2 got valid=%b key=%0d rel=%b exp 1 2 0", evt_valid, evt_key, evt_release); end
        for (int k = 0; k < 3 * TD; k++) begin
            @(negedge clk);
            checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL press_no_repeat cyc=%0d got valid=%b exp=0", k, evt_valid); end
        end
    endtask

    task automatic test_fifo_order();
        int exp_keys[3] = '{0, 1, 3};
        wait_tick();
        key_held = 4'b0000;
        repeat (2 * TD) @(negedge clk);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL order_pre got valid=%b exp=0", evt_valid); end
        wait_tick();
        key_held = 4'b1011;
        repeat (4) @(negedge clk);
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (evt_valid !== 1'b1 || evt_key !== 2'(exp_keys[i])) begin
                failures++; $display("FAIL order_pop%0d got valid=%b key=%0d exp 1 %0d", i, evt_valid, evt_key, exp_keys[i]); end
            @(negedge clk);
        end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL order_empty got valid=%b exp=0", evt_valid); end
    endtask

    task automatic test_overflow();
        wait_tick();
        key_held = 4'b0000;
        repeat (2 * TD) @(negedge clk);
        evt_ready = 1'b0;
        wait_tick();
        key_held = 4'b1111;
        repeat (5) @(negedge clk);
        checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
            failures++; $display("FAIL full_head got valid=%b key=%0d exp 1 0", evt_valid, evt_key); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
        wait_tick(); key_held = 4'b0000;
        wait_tick(); key_held = 4'b0001;
        wait_tick(); key_held = 4'b0000;
        wait_tick(); key_held = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 3 * TD; k++) begin
            checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky cyc=%0d got=%b exp=1", k, overflow); end
            checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
                failures++; $display("FAIL ovf_head cyc=%0d got valid=%b key=%0d exp 1 0", k, evt_valid, evt_key); end
            @(negedge clk);
        end
    endtask

    task automatic test_full_pop_push();
        int exp_keys[4] = '{1, 2, 3, 0};
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd1) begin
            failures++; $display("FAIL popush_head got valid=%b key=%0d exp 1 1", evt_valid, evt_key); end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_valid !== 1'b1 || evt_key !== 2'(exp_keys[i]) || evt_release !== 1'b0) begin
                failures++; $display("FAIL popush_drain%0d got valid=%b key=%0d rel=%b exp 1 %0d 0",
                                     i, evt_valid, evt_key, evt_release, exp_keys[i]); end
            @(negedge clk);
        end
`ifdef KEY_RELEASE_EVT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_valid !== 1'b1 || evt_key !== 2'(i) || evt_release !== 1'b1) begin
                failures++; $display("FAIL popush_rel%0d got valid=%b key=%0d rel=%b exp 1 %0d 1",
                                     i, evt_valid, evt_key, evt_release, i); end
            @(negedge clk);
        end
`endif
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL popush_empty got valid=%b exp=0", evt_valid); end
    endtask

    task automatic test_release_and_reset();
        int ev_key[$];
        int ev_rel[$];
        reset = 1'b1; key_held = 4'b0000; evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_clears_ovf got=%b exp=0", overflow); end
        reset = 1'b0;
        wait_tick();
        key_held = 4'b0010;
        for (int k = 1; k <= 5 * TD; k++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) begin
                ev_key.push_back(int'(evt_key));
                ev_rel.push_back(int'(evt_release));
            end
            if (k == TD) key_held = 4'b0000;
        end
        checks++; if (ev_key.size() != (REL ? 2 : 1)) begin
            failures++; $display("FAIL rel_count got=%0d exp=%0d", ev_key.size(), REL ? 2 : 1); end
        checks++; if (ev_key.size() < 1 || ev_key[0] != 1 || ev_rel[0] != 0) begin
            failures++; $display("FAIL rel_first got n=%0d exp key=1 rel=0", ev_key.size()); end
`ifdef KEY_RELEASE_EVT_EN
        checks++; if (ev_key.size() < 2 || ev_key[1] != 1 || ev_rel[1] != 1) begin
            failures++; $display("FAIL rel_second got n=%0d exp key=1 rel=1", ev_key.size()); end
`endif
        evt_ready = 1'b0;
        wait_tick();
        key_held = 4'b1111;
        repeat (4) @(negedge clk);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL queued_before_rst got valid=%b exp=1", evt_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0 || evt_key !== 2'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL mid_reset got valid=%b key=%0d ovf=%b exp 0 0 0", evt_valid, evt_key, overflow); end
        reset = 1'b0;
        repeat (TD + 1) @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL held_after_rst_early got valid=%b exp=0", evt_valid); end
        @(negedge clk);
        checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
            failures++; $display("FAIL held_after_rst got valid=%b key=%0d exp 1 0", evt_valid, evt_key); end
    endtask

    task automatic test_random();
        int e;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            checks++; if (tick !== m_tick || evt_valid !== (m_q.size() > 0) || overflow !== m_ovf) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got tick=%b valid=%b ovf=%b exp %b %b %b",
                                     k, tick, evt_valid, overflow, m_tick, m_q.size() > 0, m_ovf); end
            if (m_q.size() > 0) begin
                e = m_q[0];
                checks++; if (evt_key !== 2'(e % NK) || evt_release !== (e >= NK)) begin
                    failures++; $display("FAIL rand_head cyc=%0d got key=%0d rel=%b exp %0d %b",
                                         k, evt_key, evt_release, e % NK, e >= NK); end
            end
            reset     = ($urandom_range(0, 299) == 0);
            evt_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) key_held = 4'($urandom);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_fifo_order();
        test_overflow();
        test_full_pop_push();
        test_release_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
